// File: rtl/upsample_pkg.sv
// Shared constants for the zero-stuffing upsample read scheduler: state
// encodings, default widths and the optional underrun counter width.
package upsample_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_L      = 4;
    localparam int UNDERRUN_CNT_W = 16;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRIME    = 3'd1;
    localparam logic [2:0] RUN      = 3'd2;
    localparam logic [2:0] UNDERRUN = 3'd3;
    localparam logic [2:0] DRAIN    = 3'd4;

    // Saturating increment for the underrun event counter.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        if (v == {UNDERRUN_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + UNDERRUN_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/upsample_phase_ctr.sv
// Mod-L phase counter with synchronous clear (dominant over enable) and a
// terminal-count flag raised while the count equals L-1.
module upsample_phase_ctr #(
    parameter int L     = 4,
    parameter int CNT_W = $clog2(L)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, wrap at L-1, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/upsample_read_sched.sv
// Symbol FIFO drain scheduler: one read every L clocks, symbol in phase 0 and
// zeros elsewhere. Define UPSAMPLE_UNDERRUN_CNT_EN to add the underrun_cnt output.
module upsample_read_sched #(
    parameter int DATA_W = upsample_pkg::DEFAULT_DATA_W,
    parameter int L      = upsample_pkg::DEFAULT_L,
    parameter int CNT_W  = $clog2(L)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic [CNT_W-1:0]  phase,
    output logic              underrun,
    output logic              busy
`ifdef UPSAMPLE_UNDERRUN_CNT_EN
    ,
    output logic [upsample_pkg::UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    import upsample_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

    logic [2:0]        state_d, state_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] sample_out_d, sample_out_q;
    logic              sample_valid_d, sample_valid_q;
    logic [CNT_W-1:0]  phase_d, phase_q;
    logic              rd_en_s, underrun_s, cnt_clr_s, cnt_en_s, drain_done_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              tc_s;

    upsample_phase_ctr #(
        .L     (L),
        .CNT_W (CNT_W)
    ) u_phase_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (cnt_s),
        .tc    (tc_s)
    );

    // DRAIN ends once the last phase of the final symbol is on the output.
    assign drain_done_s = (state_q == DRAIN) && ((phase_q == LAST) || !sample_valid_q);

    // Scheduler FSM; read and underrun decisions are taken only at cnt == L-1.
    always_comb begin
        state_d    = state_q;
        rd_en_s    = 1'b0;
        underrun_s = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (enable) begin
                    state_d = PRIME;
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME: begin
                cnt_clr_s = 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    rd_en_s = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = PRIME;
                end
            end
            RUN, UNDERRUN: begin
                cnt_en_s = 1'b1;
                if (tc_s) begin
                    if (!enable) begin
                        state_d = DRAIN;
                    end else if (!fifo_empty) begin
                        rd_en_s = 1'b1;
                        state_d = RUN;
                    end else begin
                        underrun_s = 1'b1;
                        state_d    = UNDERRUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN: begin
                cnt_en_s = 1'b1;
                if (drain_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // Output pipeline: a pending read places fifo_data in phase 0, otherwise zero-stuff.
    always_comb begin
        sample_out_d   = {DATA_W{1'b0}};
        sample_valid_d = 1'b0;
        phase_d        = {CNT_W{1'b0}};
        if (rd_pend_q) begin
            sample_out_d   = fifo_data;
            sample_valid_d = 1'b1;
            phase_d        = {CNT_W{1'b0}};
        end else begin
            sample_valid_d = sample_valid_q && !drain_done_s;
            if (sample_valid_d && (phase_q != LAST)) begin
                phase_d = phase_q + CNT_W'(1);
            end else begin
                phase_d = {CNT_W{1'b0}};
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_pend_q      <= 1'b0;
            sample_out_q   <= {DATA_W{1'b0}};
            sample_valid_q <= 1'b0;
            phase_q        <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            rd_pend_q      <= rd_en_s;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            phase_q        <= phase_d;
        end
    end

`ifdef UPSAMPLE_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt_d, underrun_cnt_q;

    // Underrun event counter, cleared when streaming is re-armed from IDLE.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if ((state_q == IDLE) && (state_d == PRIME)) begin
            underrun_cnt_d = {UNDERRUN_CNT_W{1'b0}};
        end else if (underrun_s) begin
            underrun_cnt_d = sat_inc(underrun_cnt_q);
        end else begin
            underrun_cnt_d = underrun_cnt_q;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_q <= {UNDERRUN_CNT_W{1'b0}};
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign fifo_rd_en   = rd_en_s;
    assign underrun     = underrun_s;
    assign busy         = (state_q != IDLE);
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_upsample_read_sched.sv
// Directed bench for upsample_read_sched (L=4, DATA_W=8) with a queue-based
// FIFO model whose empty flag and read data are registered on clk.
module tb_upsample_read_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic [1:0] phase;
    logic       underrun;
    logic       busy;
`ifdef UPSAMPLE_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] fq[$];

    upsample_read_sched #(.DATA_W(8), .L(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .phase        (phase),
        .underrun     (underrun),
        .busy         (busy)
`ifdef UPSAMPLE_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: data valid the cycle after a read, empty flag registered.
    always @(posedge clk) begin
        if (fifo_rd_en && (fq.size() > 0)) begin
            fifo_data <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // A read strobe must never coincide with an empty FIFO.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            checks++;
            if (fifo_empty) begin
                failures++;
                $display("FAIL rd_while_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic wait_symbol(input logic [7:0] sym, input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            #1;
            if (sample_valid && (sample_out == sym)) found = 1'b1;
        end
        if (!found) timeout_fail(nm);
    endtask

    task automatic wait_idle(input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            #1;
            if (!busy && !sample_valid) found = 1'b1;
        end
        if (!found) timeout_fail(nm);
    endtask

    typedef struct packed {
        logic       en;
        logic       push;
        logic [7:0] pdata;
        logic       rd;
        logic       ur;
        logic       vld;
        logic [7:0] smp;
        logic [1:0] ph;
        logic       bsy;
    } vec_t;

    localparam int NV = 32;
    vec_t tv [NV];

    initial begin
        // Steady stream of 11,22,33 (FIFO preloaded), then enable drops at cnt==3.
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1};
        tv[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 2'd0, 1'b1};
        tv[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 2'd0, 1'b1};
        tv[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        // Underrun: one symbol 5A, empty window, then 7F lands at phase 0.
        tv[16] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        tv[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tv[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 1'b1};
        tv[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1};
        tv[24] = '{1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[25] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[26] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[27] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7F, 2'd0, 1'b1};
        tv[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1};
        tv[29] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b1};
        tv[30] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1};
        tv[31] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};

        // Reset state with a non-empty FIFO.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        repeat (3) @(negedge clk);
        #1;
        chk("rst rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst sample_out", 32'(sample_out), 32'd0);
        chk("rst sample_valid", 32'(sample_valid), 32'd0);
        chk("rst phase", 32'(phase), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
`ifdef UPSAMPLE_UNDERRUN_CNT_EN
        chk("rst underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d rd_en", i), 32'(fifo_rd_en), 32'd0);
            chk($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            enable = tv[i].en;
            if (tv[i].push) fq.push_back(tv[i].pdata);
            #1;
            chk($sformatf("row%0d rd_en", i), 32'(fifo_rd_en), 32'(tv[i].rd));
            chk($sformatf("row%0d underrun", i), 32'(underrun), 32'(tv[i].ur));
            chk($sformatf("row%0d valid", i), 32'(sample_valid), 32'(tv[i].vld));
            chk($sformatf("row%0d sample", i), 32'(sample_out), 32'(tv[i].smp));
            chk($sformatf("row%0d phase", i), 32'(phase), 32'(tv[i].ph));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].bsy));
        end

        // Enable drop at phase 1 of 22 with 44 still queued: no further read.
        @(negedge clk);
        fq.push_back(8'h22);
        fq.push_back(8'h44);
        enable = 1'b1;
        wait_symbol(8'h22, "drop wait22");
        chk("drop ph0", 32'(phase), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        #1;
        chk("drop ph1 phase", 32'(phase), 32'd1);
        chk("drop ph1 sample", 32'(sample_out), 32'd0);
        @(negedge clk);
        #1;
        chk("drop tc rd_en", 32'(fifo_rd_en), 32'd0);
        chk("drop tc phase", 32'(phase), 32'd2);
        @(negedge clk);
        #1;
        chk("drop ph3 valid", 32'(sample_valid), 32'd1);
        chk("drop ph3 phase", 32'(phase), 32'd3);
        @(negedge clk);
        #1;
        chk("drop end valid", 32'(sample_valid), 32'd0);
        chk("drop end busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("drop fifo left", 32'(fq.size()), 32'd1);

        // Asynchronous reset during phase 2 of 44, then restart through PRIME.
        fq.push_back(8'h55);
        fq.push_back(8'h66);
        enable = 1'b1;
        wait_symbol(8'h44, "rst wait44");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst ph2", 32'(phase), 32'd2);
        chk("midrst pre rd_en", 32'(fifo_rd_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst sample", 32'(sample_out), 32'd0);
        chk("midrst valid", 32'(sample_valid), 32'd0);
        chk("midrst phase", 32'(phase), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst hold rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("restart prime rd_en", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        #1;
        chk("restart gap valid", 32'(sample_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("restart sample", 32'(sample_out), 32'h55);
        chk("restart phase", 32'(phase), 32'd0);
        chk("restart valid", 32'(sample_valid), 32'd1);
        chk("restart fifo left", 32'(fq.size()), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        wait_idle("restart drain");

`ifdef UPSAMPLE_UNDERRUN_CNT_EN
        // Three underrun windows, then re-arm from IDLE clears the count.
        begin
            int n = 0;
            @(negedge clk);
            fq.delete();
            fq.push_back(8'hA1);
            enable = 1'b1;
            for (int k = 0; k < 60 && n < 3; k++) begin
                @(negedge clk);
                #1;
                if (underrun) n++;
            end
            if (n < 3) timeout_fail("ucnt wait");
            @(negedge clk);
            #1;
            chk("ucnt three", 32'(underrun_cnt), 32'd3);
            enable = 1'b0;
            wait_idle("ucnt drain");
            chk("ucnt idle hold", 32'(underrun_cnt), 32'd3);
            @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            #1;
            chk("ucnt cleared", 32'(underrun_cnt), 32'd0);
            wait_idle("ucnt end");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upsample_read_sched.md
Name: upsample_read_sched

Overview:
Single-clock controller that drains the symbol FIFO at symbol rate and produces a zero-stuffed sample stream for the interpolation filter. It issues one FIFO read every L clocks, places each symbol in phase 0 and zeros in phases 1..L-1, and keeps the filter fed with zeros on FIFO underrun. It sits between the read side of the symbol FIFO (read_clk domain) and the pulse-shaping filter input.

Parameters:
DATA_W, 8, symbol/sample width in bits (matches FIFO data width)
L, 4, upsampling factor, legal range 2..256
CNT_W, $clog2(L), phase counter width (derived; not overridden)

Ports:
clk  in  1  symbol/sample clock (same clock as the FIFO read side)
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/continue streaming; level-sensitive
fifo_empty  in  1  FIFO empty flag (registered, FIFO read domain)
fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  out  1  FIFO read strobe, 1-cycle pulse
sample_out  out  DATA_W  zero-stuffed sample to filter, registered
sample_valid  out  1  sample_out carries a stream sample this cycle
phase  out  CNT_W  upsample phase of sample_out (0 = symbol slot)
underrun  out  1  1-cycle pulse: a scheduled read found fifo_empty=1
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: fifo_rd_en=0, sample_out=0, sample_valid=0, phase=0, underrun=0, busy=0, state=IDLE, cnt=0, rd_pend=0.
- Reset asserted mid-stream clears everything immediately. No read is issued in the reset cycle. Streaming restarts only through PRIME.
- States:
  - IDLE: outputs quiet. enable=1 -> PRIME.
  - PRIME: wait for fifo_empty=0. On that cycle assert fifo_rd_en, set cnt=0 and go to RUN. enable=0 in PRIME -> IDLE with no read.
  - RUN: cnt increments mod L every cycle. At cnt==L-1:
    - fifo_empty=0 and enable=1 -> assert fifo_rd_en.
    - fifo_empty=1 and enable=1 -> underrun pulse, go to UNDERRUN.
    - enable=0 -> go to DRAIN.
  - UNDERRUN: cnt keeps running; zeros are emitted in every phase, including phase 0. At cnt==L-1:
    - fifo_empty=0 -> fifo_rd_en, back to RUN.
    - still empty -> another underrun pulse.
    - enable=0 -> DRAIN.
  - DRAIN: finish emitting the L samples of the last symbol, then go to IDLE. fifo_rd_en is never asserted.
- Read pipeline:
  - rd_pend <= fifo_rd_en.
  - When rd_pend=1, sample_out <= fifo_data and phase <= 0 (symbol slot).
  - Otherwise sample_out <= 0 and phase <= phase+1 mod L.
- Latency: fifo_rd_en at cycle t -> symbol on sample_out at t+2.
- Reads are spaced exactly L cycles apart; sample_out is strictly periodic with period L while running.
- sample_valid:
  - Goes high 2 cycles after the first read.
  - Stays high continuously through RUN, UNDERRUN and DRAIN.
  - Drops the cycle after phase L-1 of the final symbol.
- Simultaneous events:
  - fifo_empty deassert in the same cycle as an underrun decision: the empty flag sampled that cycle wins (underrun).
  - enable falling at cnt==L-1 suppresses the read.
- fifo_rd_en is never asserted while fifo_empty=1.

Optional Feature:
UPSAMPLE_UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt [15:0] (reset 0), which increments on each underrun pulse, saturates at 16'hFFFF and is cleared by the IDLE->PRIME transition.
- Undefined: the port and counter are absent; underrun pulse behaviour is unchanged.

Decomposition:
- Package upsample_pkg holds:
  - state encoding constants: IDLE=3'd0, PRIME=3'd1, RUN=3'd2, UNDERRUN=3'd3, DRAIN=3'd4;
  - default DATA_W and L;
  - underrun counter width 16.
- Sub-module upsample_phase_ctr: mod-L counter with clear and terminal-count output (cnt==L-1). It is instantiated once for cnt.

Test Plan:
- Reset, L=4: hold rst_n=0 -> all outputs 0, busy=0. Release with enable=0 -> no fifo_rd_en for 20 cycles.
- Steady stream, L=4: FIFO preloaded with 8'h11,8'h22,8'h33, enable=1 -> sample_out = 11,0,0,0,22,0,0,0,33,0,0,0. Phase 0,1,2,3 repeating; reads 4 cycles apart; first symbol 2 cycles after the first read.
- Underrun: 1 symbol 8'h5A, then empty for 6 cycles -> 5A,0,0,0 then zeros. underrun pulses once, at the next cnt==3. Write 8'h7F -> reads at the following cnt==3; 7F lands at phase 0; sample_valid never drops.
- Enable drop mid-stream: deassert at phase 1 of 8'h22 -> 22,0,0,0 completes, no further read, then sample_valid=0 and busy=0.
- Reset mid-run: rst_n low during phase 2 -> outputs zero asynchronously. After release with enable=1, PRIME re-reads from the FIFO and the output restarts at phase 0.
- UPSAMPLE_UNDERRUN_CNT_EN defined: 3 underrun windows -> underrun_cnt=3. Re-enable from IDLE -> underrun_cnt=0.
